// File: rtl/sh_tick_pkg.sv
// Shared definitions for the SH-2 tick prescaler register block.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sh_tick_pkg;

    // Register offsets relative to the block base. All registers are long-aligned.
    localparam logic [31:0] CTRL_OFS    = 32'h0000_0000;
    localparam logic [31:0] CNT_OFS     = 32'h0000_0004;
    localparam logic [31:0] CH_OFS_BASE = 32'h0000_0008;

    // CTRL fields
    localparam int CTRL_RUN_BIT = 0;
    localparam int CTRL_CLR_BIT = 1;

    // CHn fields
    localparam int CH_SEL_LSB = 0;
    localparam int CH_SEL_W   = 5;
    localparam int CH_EN_BIT  = 7;

    // True when addr falls inside [base, base+size). The subtraction wraps,
    // so addresses below base become huge offsets and fail the compare.
    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
        logic [31:0] ofs;
        ofs = addr - base;
        return (ofs < size);
    endfunction

endpackage

// File: rtl/sh_tick_chan.sv
// Programmable channel tick: SEL/EN register, tap mux and registered tick output.
// Latency: ch_ce asserts one CLK after the qualifying tap_fire cycle.
// Backpressure: none; register writes are single-cycle and always accepted.
//
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   soft_rst    synchronous clear, already qualified with the clock enable
//   wr          commit strobe for this channel register (already qualified)
//   wr_dat      byte lane 0 of the write data
//   tap_fire    per-tap fire conditions from the counter (already qualified)
//   reg_val     register contents for read-back
//   ch_ce       registered channel tick
module sh_tick_chan
    import sh_tick_pkg::*;
#(
    parameter int DIV_W = 13
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             soft_rst,
    input  logic             wr,
    input  logic [7:0]       wr_dat,
    input  logic [DIV_W-1:0] tap_fire,
    output logic [7:0]       reg_val,
    output logic             ch_ce
);

    logic [CH_SEL_W-1:0] sel;
    logic                en;
    logic                tap_hit;
    logic [1:0]          unused_dat;

    // Register bits 6:5 carry no state; their write data is discarded.
    assign unused_dat = wr_dat[6:5];

    // SEL=k selects tap k (tap_fire[k-1]); SEL=0 or SEL>DIV_W matches nothing.
    always_comb begin
        tap_hit = 1'b0;
        for (int i = 0; i < DIV_W; i++) begin
            if (sel == CH_SEL_W'(i + 1)) begin
                tap_hit = tap_fire[i];
            end
        end
    end

    always_comb begin
        reg_val                            = '0;
        reg_val[CH_SEL_LSB +: CH_SEL_W]    = sel;
        reg_val[CH_EN_BIT]                 = en;
    end

    // Register update and tick output share one edge, so a write coinciding
    // with a tap is judged on the old SEL/EN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel   <= '0;
            en    <= 1'b0;
            ch_ce <= 1'b0;
        end else begin
            ch_ce <= en & tap_hit;
            if (soft_rst) begin
                sel <= '0;
                en  <= 1'b0;
            end else if (wr) begin
                sel <= wr_dat[CH_SEL_LSB +: CH_SEL_W];
                en  <= wr_dat[CH_EN_BIT];
            end
        end
    end

endmodule

// File: rtl/sh_tick_gen.sv
// Clock-enable prescaler: free-running counter, CLK_CE/2^k taps and NUM_CH programmable channel ticks.
// Latency: taps/channels assert one CLK after the CE_R cycle meeting the tap condition; reads are combinational.
// Backpressure: none; zero-wait bus slave, IBUS_BUSY tied low.
//
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   CE_R         clock enable; all state advances only when high
//   RES_N        synchronous soft reset, active-low, sampled on CE_R
//   IBUS_*       peripheral bus slave (address, data in/out, byte enables,
//                write strobe, request, busy, active/select)
//   TAP_CE       TAP_CE[k-1] ticks at CLK_CE/2^k
//   CH_CE        programmable channel ticks
module sh_tick_gen
    import sh_tick_pkg::*;
#(
    parameter int          DIV_W     = 13,
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FE40
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE_R,
    input  logic              RES_N,
    input  logic [31:0]       IBUS_A,
    input  logic [31:0]       IBUS_DI,
    output logic [31:0]       IBUS_DO,
    input  logic [3:0]        IBUS_BA,
    input  logic              IBUS_WE,
    input  logic              IBUS_REQ,
    output logic              IBUS_BUSY,
    output logic              IBUS_ACT,
    output logic [DIV_W-1:0]  TAP_CE,
    output logic [NUM_CH-1:0] CH_CE
);

    localparam int WIN_BYTES = 8 + 4 * NUM_CH;

    logic [DIV_W-1:0] cnt;
    logic             run;
    logic [DIV_W-1:0] tap_fire;
    logic [DIV_W-1:0] tap_q;

    logic [31:0]      ofs;
    logic [31:0]      ofs_al;
    logic             hit;
    logic             soft_rst;
    logic             wr_commit;
    logic             ctrl_wr;
    logic             clr_wr;
    logic             advance;
    logic [7:0]       ch_reg [NUM_CH];
    logic [31:0]      rd_dat;
    logic [28:0]      unused_bits;

    assign unused_bits = {IBUS_DI[31:8], IBUS_BA[3:1], ofs[1:0]};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign ofs    = IBUS_A - BASE_ADDR;
    assign ofs_al = {ofs[31:2], 2'b00};
    assign hit    = win_hit(IBUS_A, BASE_ADDR, 32'(WIN_BYTES));

    assign IBUS_ACT  = IBUS_REQ & hit;
    assign IBUS_BUSY = 1'b0;

    assign soft_rst  = CE_R & ~RES_N;
    // Soft reset takes priority over any write in the same cycle.
    assign wr_commit = CE_R & RES_N & IBUS_REQ & IBUS_WE & hit & IBUS_BA[0];
    assign ctrl_wr   = wr_commit & (ofs_al == CTRL_OFS);
    assign clr_wr    = ctrl_wr & IBUS_DI[CTRL_CLR_BIT];

    // ------------------------------------------------------------------
    // Counter and taps
    // ------------------------------------------------------------------
    // A CLR cycle loads 0 and suppresses every tap, even at all-ones.
    assign advance = CE_R & RES_N & run & ~clr_wr;

    for (genvar i = 0; i < DIV_W; i++) begin : g_tap
        assign tap_fire[i] = advance & (&cnt[i:0]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt   <= '0;
            run   <= 1'b1;
            tap_q <= '0;
        end else begin
            // tap_fire is zero whenever CE_R is low, so pulses last one CLK.
            tap_q <= tap_fire;
            if (soft_rst) begin
                cnt <= '0;
                run <= 1'b1;
            end else if (CE_R) begin
                if (clr_wr) begin
                    cnt <= '0;
                end else if (run) begin
                    cnt <= cnt + 1'b1;
                end
                if (ctrl_wr) begin
                    run <= IBUS_DI[CTRL_RUN_BIT];
                end
            end
        end
    end

    assign TAP_CE = tap_q;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_commit & (ofs_al == (CH_OFS_BASE + 32'(4 * n)));

        sh_tick_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .soft_rst (soft_rst),
            .wr       (ch_wr),
            .wr_dat   (IBUS_DI[7:0]),
            .tap_fire (tap_fire),
            .reg_val  (ch_reg[n]),
            .ch_ce    (CH_CE[n])
        );
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_dat = '0;
        if (IBUS_REQ && hit) begin
            if (ofs_al == CTRL_OFS) begin
                rd_dat[CTRL_RUN_BIT] = run;
            end else if (ofs_al == CNT_OFS) begin
                rd_dat[DIV_W-1:0] = cnt;
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (ofs_al == (CH_OFS_BASE + 32'(4 * n))) begin
                    rd_dat[7:0] = ch_reg[n];
                end
            end
        end
    end

    assign IBUS_DO = rd_dat;

endmodule

// File: tb/tb_sh_tick_gen.sv
// Self-checking bench for sh_tick_gen: register table, directed corner sequences, random traffic vs. model.
// Latency: model predicts outputs one CLK after each applied cycle.
// Backpressure: n/a.
module tb_sh_tick_gen;

    localparam int          DIV_W     = 13;
    localparam int          NUM_CH    = 4;
    localparam logic [31:0] BASE_ADDR = 32'hFFFF_FE40;
    localparam int          WIN       = 8 + 4 * NUM_CH;
    localparam int          CNT_MOD   = 1 << DIV_W;

    logic              CLK;
    logic              RST_N;
    logic              CE_R;
    logic              RES_N;
    logic [31:0]       IBUS_A;
    logic [31:0]       IBUS_DI;
    logic [31:0]       IBUS_DO;
    logic [3:0]        IBUS_BA;
    logic              IBUS_WE;
    logic              IBUS_REQ;
    logic              IBUS_BUSY;
    logic              IBUS_ACT;
    logic [DIV_W-1:0]  TAP_CE;
    logic [NUM_CH-1:0] CH_CE;

    sh_tick_gen #(
        .DIV_W     (DIV_W),
        .NUM_CH    (NUM_CH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE_R      (CE_R),
        .RES_N     (RES_N),
        .IBUS_A    (IBUS_A),
        .IBUS_DI   (IBUS_DI),
        .IBUS_DO   (IBUS_DO),
        .IBUS_BA   (IBUS_BA),
        .IBUS_WE   (IBUS_WE),
        .IBUS_REQ  (IBUS_REQ),
        .IBUS_BUSY (IBUS_BUSY),
        .IBUS_ACT  (IBUS_ACT),
        .TAP_CE    (TAP_CE),
        .CH_CE     (CH_CE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: counter value, RUN flag, channel registers.
    int         m_cnt;
    bit         m_run;
    logic [7:0] m_ch [NUM_CH];

    // DUT bus outputs sampled before the edge of the last step.
    logic [31:0] last_do;
    logic        last_act;

    typedef struct {
        bit          we;
        logic [31:0] ofs;
        logic [31:0] di;
        logic [3:0]  ba;
        logic [31:0] exp_do;
        bit          exp_act;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_run = 1'b1;
        for (int n = 0; n < NUM_CH; n++) m_ch[n] = 8'h00;
    endtask

    // One CLK: drive inputs, check combinational read, then check ticks after the edge.
    task automatic step(input bit ce, input bit rn, input bit req, input bit we,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
        logic [31:0]       o;
        logic [31:0]       exp_do;
        logic [DIV_W-1:0]  exp_tap;
        logic [NUM_CH-1:0] exp_ch;
        bit                hit;
        bit                wc;
        bit                clr;
        int                widx;
        int                sel;
        int                p;
        CE_R = ce; RES_N = rn; IBUS_REQ = req; IBUS_WE = we;
        IBUS_A = a; IBUS_DI = d; IBUS_BA = ba;
        o    = a - BASE_ADDR;
        hit  = (o < 32'(WIN));
        widx = hit ? int'(o >> 2) : -1;
        exp_do = 32'h0;
        if (req && hit) begin
            if (widx == 0)      exp_do = {31'h0, m_run};
            else if (widx == 1) exp_do = 32'(m_cnt);
            else                exp_do = {24'h0, m_ch[widx-2]};
        end
        #1;
        last_do  = IBUS_DO;
        last_act = IBUS_ACT;
        chk("ibus_do", IBUS_DO, exp_do);
        chk("ibus_act", {31'h0, IBUS_ACT}, {31'h0, req && hit});

        wc  = ce && rn && req && we && hit && ba[0];
        clr = wc && (widx == 0) && d[1];
        for (int k = 1; k <= DIV_W; k++) begin
            p = 1 << k;
            exp_tap[k-1] = ce && rn && m_run && !clr && ((m_cnt % p) == p - 1);
        end
        for (int n = 0; n < NUM_CH; n++) begin
            sel = int'(m_ch[n][4:0]);
            exp_ch[n] = 1'b0;
            if (m_ch[n][7] && sel >= 1 && sel <= DIV_W) exp_ch[n] = exp_tap[sel-1];
        end

        @(posedge CLK);
        #1;
        chk("tap_ce", 32'(TAP_CE), 32'(exp_tap));
        chk("ch_ce", 32'(CH_CE), 32'(exp_ch));

        if (ce) begin
            if (!rn) begin
                model_reset();
            end else begin
                if (clr)        m_cnt = 0;
                else if (m_run) m_cnt = (m_cnt + 1) % CNT_MOD;
                if (wc) begin
                    if (widx == 0)      m_run = d[0];
                    else if (widx >= 2) m_ch[widx-2] = d[7:0] & 8'h9F;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 1, 0, BASE_ADDR + 32'h4, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
        step(1, 1, 1, 1, BASE_ADDR + ofs, d, 4'h1);
    endtask

    task automatic run_to(input int target);
        for (int g = 0; g < 3 * CNT_MOD && m_cnt != target; g++) idle(1);
    endtask

    vec_t tbl [17];
    logic [3:0] tap1_exp;

    initial begin
        tbl[0]  = '{0, 32'h00, 32'h0,         4'h0, 32'h1,  1};
        tbl[1]  = '{0, 32'h08, 32'h0,         4'h0, 32'h0,  1};
        tbl[2]  = '{1, 32'h0C, 32'h9F,        4'h1, 32'h0,  1};
        tbl[3]  = '{0, 32'h0C, 32'h0,         4'h0, 32'h9F, 1};
        tbl[4]  = '{1, 32'h10, 32'hFFFF_FF83, 4'hE, 32'h0,  1};
        tbl[5]  = '{0, 32'h10, 32'h0,         4'h0, 32'h0,  1};
        tbl[6]  = '{1, 32'h10, 32'h1234_56E3, 4'hF, 32'h0,  1};
        tbl[7]  = '{0, 32'h10, 32'h0,         4'h0, 32'h83, 1};
        tbl[8]  = '{0, 32'h18, 32'h0,         4'h0, 32'h0,  0};
        tbl[9]  = '{0, 32'hFFFF_FFFC, 32'h0,  4'h0, 32'h0,  0};
        tbl[10] = '{1, 32'h18, 32'hFF,        4'hF, 32'h0,  0};
        tbl[11] = '{1, 32'h10, 32'h00,        4'h1, 32'h83, 1};
        tbl[12] = '{1, 32'h08, 32'h83,        4'h1, 32'h0,  1};
        tbl[13] = '{0, 32'h08, 32'h0,         4'h0, 32'h83, 1};
        tbl[14] = '{0, 32'h14, 32'h0,         4'h0, 32'h0,  1};
        tbl[15] = '{1, 32'h00, 32'h0,         4'h0, 32'h1,  1};
        tbl[16] = '{0, 32'h00, 32'h0,         4'h0, 32'h1,  1};

        RST_N = 1'b0; CE_R = 1'b0; RES_N = 1'b1; IBUS_REQ = 1'b0; IBUS_WE = 1'b0;
        IBUS_A = 32'h0; IBUS_DI = 32'h0; IBUS_BA = 4'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_tap", 32'(TAP_CE), 32'h0);
        chk("reset_ch", 32'(CH_CE), 32'h0);
        chk("busy", {31'h0, IBUS_BUSY}, 32'h0);
        RST_N = 1'b1;

        // First ÷4 pulse follows the cycle with CNT=3.
        tap1_exp = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("tap1_first", {31'h0, TAP_CE[1]}, {31'h0, tap1_exp[i]});
        end

        // Register table.
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 1, tbl[i].we, BASE_ADDR + tbl[i].ofs, tbl[i].di, tbl[i].ba);
            chk($sformatf("tbl%0d_do", i), last_do, tbl[i].exp_do);
            chk($sformatf("tbl%0d_act", i), {31'h0, last_act}, {31'h0, tbl[i].exp_act});
        end

        // CH0=83, CH1=9F: wrap fires every tap and only CH0.
        run_to(CNT_MOD - 1);
        idle(1);
        chk("wrap_taps", 32'(TAP_CE), 32'(CNT_MOD - 1));
        chk("wrap_ch", 32'(CH_CE), 32'h1);

        idle(32);
        wr(32'h08, 32'h05);
        idle(32);

        // CE_R every third CLK.
        for (int i = 0; i < 48; i++) step((i % 3) == 0, 1, 0, 0, 32'h0, 32'h0, 4'h0);

        // CLR on the all-ones cycle.
        run_to(CNT_MOD - 1);
        wr(32'h00, 32'h03);
        chk("clr_no_tap", 32'(TAP_CE), 32'h0);
        idle(1);
        chk("clr_cnt0", last_do, 32'h0);
        idle(3);

        // RUN=0 holds the counter, RUN=1 resumes.
        wr(32'h00, 32'h00);
        idle(100);
        wr(32'h00, 32'h01);
        idle(20);

        // Soft reset.
        wr(32'h08, 32'h83);
        wr(32'h00, 32'h00);
        step(1, 0, 1, 1, BASE_ADDR + 32'h0C, 32'h85, 4'h1);
        step(1, 1, 1, 0, BASE_ADDR + 32'h00, 32'h0, 4'h0);
        chk("res_ctrl", last_do, 32'h1);
        step(1, 1, 1, 0, BASE_ADDR + 32'h08, 32'h0, 4'h0);
        chk("res_ch0", last_do, 32'h0);

        // Async reset in the middle of a pulse.
        wr(32'h08, 32'h83);
        run_to(7);
        idle(1);
        RST_N = 1'b0;
        IBUS_REQ = 1'b1; IBUS_WE = 1'b0; IBUS_A = BASE_ADDR + 32'h4;
        #2;
        chk("arst_tap", 32'(TAP_CE), 32'h0);
        chk("arst_ch", 32'(CH_CE), 32'h0);
        chk("arst_cnt", IBUS_DO, 32'h0);
        model_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int          r;
            logic [31:0] a;
            logic [31:0] d;
            bit          we;
            r  = int'($urandom_range(0, NUM_CH + 3));
            a  = (r == NUM_CH + 3) ? BASE_ADDR - 32'h4 : BASE_ADDR + 32'(4 * r);
            we = ($urandom_range(0, 3) == 0);
            d  = $urandom;
            if (r == 0) begin
                d[0] = ($urandom_range(0, 7) != 0);
                d[1] = ($urandom_range(0, 15) == 0);
            end else if (r >= 2) begin
                d[4:0] = 5'($urandom_range(0, DIV_W + 2));
                d[7]   = ($urandom_range(0, 3) != 0);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0,
                 $urandom_range(0, 1) == 1, we, a, d, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
